// File: rtl/cache_ctrl_if.sv
// CPU handshake, cache_memory/mem_stub controls and statistics seen by the cache controller FSM.
interface cache_ctrl_if #(
   parameter int unsigned CNT_WIDTH = 16
);
   logic                 cpu_req_valid;
   logic                 cpu_req_type;
   logic                 cpu_ready;
   logic                 cpu_done;
   logic                 cpu_error;
   logic                 hit;
   logic                 dirty_bit;
   logic                 req_type;
   logic                 read_en_cache;
   logic                 write_en_cache;
   logic                 read_en_mem;
   logic                 write_en_mem;
   logic                 refill;
   logic [CNT_WIDTH-1:0] hit_count;
   logic [CNT_WIDTH-1:0] miss_count;

   // CPU plus datapath environment
   modport master (
      output cpu_req_valid, cpu_req_type, hit, dirty_bit,
      input  cpu_ready, cpu_done, cpu_error, req_type, read_en_cache, write_en_cache,
             read_en_mem, write_en_mem, refill, hit_count, miss_count
   );

   // Controller FSM
   modport slave (
      input  cpu_req_valid, cpu_req_type, hit, dirty_bit,
      output cpu_ready, cpu_done, cpu_error, req_type, read_en_cache, write_en_cache,
             read_en_mem, write_en_mem, refill, hit_count, miss_count
   );
endinterface

// File: rtl/cache_ctrl_fsm.sv
// Control FSM for a 2-way set-associative cache datapath: compare, write-back, allocate, re-compare.
// Every output is registered; enables are decoded from the next state so they line up with the state.
module cache_ctrl_fsm #(
   parameter int unsigned MEM_LATENCY = 3,
   parameter int unsigned CNT_WIDTH   = 16
) (
   input  logic          clk,
   input  logic          rst,
   cache_ctrl_if.slave   bus
);
   localparam int unsigned    CW       = 4;
   localparam logic [CW-1:0]  CNT_LOAD = CW'(MEM_LATENCY - 1);

   typedef enum logic [2:0] {
      IDLE, COMPARE, WRITE_BACK, ALLOCATE, RECOMPARE, DONE
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          req_type_n;
   logic          ready_n, done_n, error_n, refill_n;
   logic          rd_cache_n, wr_cache_n, rd_mem_n, wr_mem_n;
   logic          hit_inc, miss_inc;

   // Next state, memory-transfer counter and next registered outputs
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      req_type_n = bus.req_type;
      ready_n    = 1'b0;
      done_n     = 1'b0;
      error_n    = 1'b0;
      refill_n   = 1'b0;
      rd_cache_n = 1'b0;
      wr_cache_n = 1'b0;
      rd_mem_n   = 1'b0;
      wr_mem_n   = 1'b0;
      hit_inc    = 1'b0;
      miss_inc   = 1'b0;

      unique case (state)
         IDLE: if (bus.cpu_req_valid) begin
            req_type_n = bus.cpu_req_type;
            state_n    = COMPARE;
         end
         COMPARE: begin
            hit_inc  = bus.hit;
            miss_inc = ~bus.hit;
            if (bus.hit) begin
               state_n = DONE;
            end else begin
               state_n = bus.dirty_bit ? WRITE_BACK : ALLOCATE;
               cnt_n   = CNT_LOAD;
            end
         end
         WRITE_BACK: if (cnt == '0) begin
            state_n = ALLOCATE;
            cnt_n   = CNT_LOAD;
         end else begin
            cnt_n = cnt - CW'(1);
         end
         ALLOCATE: if (cnt == '0) begin
            state_n = RECOMPARE;
         end else begin
            cnt_n = cnt - CW'(1);
         end
         RECOMPARE: begin
            state_n = bus.hit ? DONE : IDLE;
            error_n = ~bus.hit;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase

      unique case (state_n)
         IDLE:       ready_n = 1'b1;
         COMPARE: begin
            rd_cache_n = ~req_type_n;
            wr_cache_n = req_type_n;
         end
         WRITE_BACK: begin
            rd_cache_n = 1'b1;
            wr_mem_n   = 1'b1;
         end
         ALLOCATE: begin
            rd_mem_n   = 1'b1;
            wr_cache_n = (cnt_n == '0);
         end
         RECOMPARE: begin
            refill_n   = 1'b1;
            rd_cache_n = ~req_type_n;
            wr_cache_n = req_type_n;
         end
         DONE:       done_n = 1'b1;
         default:    ready_n = 1'b0;
      endcase
   end

   // State, outputs and saturating statistics
   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= IDLE;
         cnt                <= '0;
         bus.req_type       <= 1'b0;
         bus.cpu_ready      <= 1'b1;
         bus.cpu_done       <= 1'b0;
         bus.cpu_error      <= 1'b0;
         bus.refill         <= 1'b0;
         bus.read_en_cache  <= 1'b0;
         bus.write_en_cache <= 1'b0;
         bus.read_en_mem    <= 1'b0;
         bus.write_en_mem   <= 1'b0;
         bus.hit_count      <= '0;
         bus.miss_count     <= '0;
      end else begin
         state              <= state_n;
         cnt                <= cnt_n;
         bus.req_type       <= req_type_n;
         bus.cpu_ready      <= ready_n;
         bus.cpu_done       <= done_n;
         bus.cpu_error      <= error_n;
         bus.refill         <= refill_n;
         bus.read_en_cache  <= rd_cache_n;
         bus.write_en_cache <= wr_cache_n;
         bus.read_en_mem    <= rd_mem_n;
         bus.write_en_mem   <= wr_mem_n;
         if (hit_inc && (bus.hit_count != '1))
            bus.hit_count <= bus.hit_count + CNT_WIDTH'(1);
         if (miss_inc && (bus.miss_count != '1))
            bus.miss_count <= bus.miss_count + CNT_WIDTH'(1);
      end
   end
endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Directed bench for cache_ctrl_fsm (MEM_LATENCY=3, CNT_WIDTH=2): per-request vector table
// plus hand-written reset-abort and saturation/held-valid sequences.
module tb_cache_ctrl_fsm;
   localparam int unsigned CNT_WIDTH = 2;

   logic clk = 1'b0;
   logic rst;
   logic tb_hit_cmp, tb_hit_re;
   int   checks = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   cache_ctrl_if #(.CNT_WIDTH(CNT_WIDTH)) bif ();

   // Hit source: one value for the first compare, another for the post-refill compare
   assign bif.hit = bif.refill ? tb_hit_re : tb_hit_cmp;

   cache_ctrl_fsm #(.MEM_LATENCY(3), .CNT_WIDTH(CNT_WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   typedef struct {
      logic rtype;
      logic hit_cmp;
      logic dirty;
      logic hit_re;
      int   end_cyc;
      logic exp_err;
      int   wem;
      int   rem;
      int   wec;
      int   rec;
      int   rfl;
      int   wec_last;
      int   hits;
      int   misses;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
      else passed++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      for (int n = 0; n < 50; n++) begin
         if (bif.cpu_ready) return;
         step();
      end
      check("wait_ready_timeout", 0, 1);
   endtask

   // Issue one request and tally enables until cpu_done or cpu_error
   task automatic run_vec(input int i);
      vec_t v;
      int   cyc, wem, rem, wec, rec, rfl, ovl, wec_last;
      logic got_done, got_err;
      v = vecs[i];
      wem = 0; rem = 0; wec = 0; rec = 0; rfl = 0; ovl = 0; wec_last = 0;
      got_done = 1'b0; got_err = 1'b0;
      wait_ready();
      tb_hit_cmp        = v.hit_cmp;
      tb_hit_re         = v.hit_re;
      bif.dirty_bit     = v.dirty;
      bif.cpu_req_type  = v.rtype;
      bif.cpu_req_valid = 1'b1;
      step();
      bif.cpu_req_valid = 1'b0;
      for (cyc = 1; cyc <= 30; cyc++) begin
         if (bif.write_en_mem)   wem++;
         if (bif.read_en_mem)    rem++;
         if (bif.read_en_cache)  rec++;
         if (bif.refill)         rfl++;
         if (bif.write_en_cache) begin wec++; wec_last = cyc; end
         if (bif.read_en_mem && bif.write_en_mem) ovl++;
         if (bif.cpu_done && bif.cpu_error)       ovl++;
         if (bif.cpu_done || bif.cpu_error) begin
            got_done = bif.cpu_done;
            got_err  = bif.cpu_error;
            break;
         end
         step();
      end
      check($sformatf("v%0d_end_cycle", i), cyc, v.end_cyc);
      check($sformatf("v%0d_error", i), int'(got_err), int'(v.exp_err));
      check($sformatf("v%0d_done", i), int'(got_done), int'(!v.exp_err));
      check($sformatf("v%0d_write_en_mem_cycles", i), wem, v.wem);
      check($sformatf("v%0d_read_en_mem_cycles", i), rem, v.rem);
      check($sformatf("v%0d_write_en_cache_cycles", i), wec, v.wec);
      check($sformatf("v%0d_write_en_cache_last", i), wec_last, v.wec_last);
      check($sformatf("v%0d_read_en_cache_cycles", i), rec, v.rec);
      check($sformatf("v%0d_refill_cycles", i), rfl, v.rfl);
      check($sformatf("v%0d_overlap", i), ovl, 0);
      check($sformatf("v%0d_hit_count", i), int'(bif.hit_count), v.hits);
      check($sformatf("v%0d_miss_count", i), int'(bif.miss_count), v.misses);
      step();
      check($sformatf("v%0d_pulse_end", i), int'(bif.cpu_done | bif.cpu_error), 0);
      check($sformatf("v%0d_ready_after", i), int'(bif.cpu_ready), 1);
   endtask

   initial begin
      int accepts, dones, quiet;
      //          type  hitc  dirty hitr  end err   wem rem wec rec rfl wlast hits miss
      vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 2, 1'b0, 0, 0, 0, 1, 0, 0, 1, 0};  // read hit
      vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 2, 1'b0, 0, 0, 1, 0, 0, 1, 2, 0};  // write hit
      vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 6, 1'b0, 0, 3, 1, 2, 1, 4, 2, 1};  // clean read miss
      vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 9, 1'b0, 3, 3, 3, 3, 1, 8, 2, 2};  // dirty write miss
      vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 9, 1'b0, 3, 3, 1, 5, 1, 7, 2, 3};  // dirty read miss
      vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 6, 1'b1, 0, 3, 1, 2, 1, 4, 2, 3};  // refill still misses

      rst = 1'b1;
      bif.cpu_req_valid = 1'b0;
      bif.cpu_req_type  = 1'b0;
      bif.dirty_bit     = 1'b0;
      tb_hit_cmp        = 1'b0;
      tb_hit_re         = 1'b0;
      step();
      step();
      check("rst_ready", int'(bif.cpu_ready), 1);
      check("rst_done", int'(bif.cpu_done), 0);
      check("rst_error", int'(bif.cpu_error), 0);
      check("rst_req_type", int'(bif.req_type), 0);
      check("rst_enables", int'({bif.read_en_cache, bif.write_en_cache, bif.read_en_mem,
                                 bif.write_en_mem, bif.refill}), 0);
      check("rst_hit_count", int'(bif.hit_count), 0);
      check("rst_miss_count", int'(bif.miss_count), 0);
      rst = 1'b0;
      step();
      check("idle_ready", int'(bif.cpu_ready), 1);

      for (int i = 0; i < 6; i++) run_vec(i);

      // Reset in the second write-back cycle aborts silently and clears statistics
      wait_ready();
      tb_hit_cmp        = 1'b0;
      tb_hit_re         = 1'b1;
      bif.dirty_bit     = 1'b1;
      bif.cpu_req_type  = 1'b1;
      bif.cpu_req_valid = 1'b1;
      step();
      bif.cpu_req_valid = 1'b0;
      step();
      step();
      check("wb2_write_en_mem", int'(bif.write_en_mem), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort_enables", int'({bif.read_en_cache, bif.write_en_cache, bif.read_en_mem,
                                   bif.write_en_mem, bif.refill}), 0);
      check("abort_ready", int'(bif.cpu_ready), 1);
      check("abort_hit_count", int'(bif.hit_count), 0);
      check("abort_miss_count", int'(bif.miss_count), 0);
      check("abort_done_error", int'(bif.cpu_done | bif.cpu_error), 0);
      quiet = 0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (bif.cpu_done || bif.cpu_error || !bif.cpu_ready) quiet++;
      end
      check("abort_stays_idle", quiet, 0);

      // Valid held high: one request per IDLE visit; hit_count saturates at 3
      tb_hit_cmp        = 1'b1;
      bif.dirty_bit     = 1'b0;
      bif.cpu_req_type  = 1'b0;
      bif.cpu_req_valid = 1'b1;
      accepts = 0;
      dones   = 0;
      for (int c = 0; c < 15; c++) begin
         if (bif.cpu_ready) accepts++;
         if (bif.cpu_done) begin
            dones++;
            check($sformatf("sat_hit_count_%0d", dones), int'(bif.hit_count),
                  (dones > 3) ? 3 : dones);
         end
         step();
      end
      bif.cpu_req_valid = 1'b0;
      check("held_valid_accepts", accepts, 5);
      check("held_valid_dones", dones, 5);
      for (int c = 0; c < 4; c++) step();
      check("sat_hit_final", int'(bif.hit_count), 3);
      check("sat_miss_final", int'(bif.miss_count), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
